ser_code_tx: RTL
================

Name: ser_code_tx

Overview:
- Transmit side of the digital-safe serial code link.
- Latches an N-bit code on a start request and shifts it out MSB first on ser_valid/ser_data, one bit per valid pulse, with a programmable idle gap between bits.
- After the last bit, waits for the safe's response (unlock / incorrect) or a timeout, then reports the result.
- Sits between the keypad/switch front end and the safe FSM.

Parameters:
- N, 4, code width in bits (2..16).
- GAP, 2, idle cycles (ser_valid low) between consecutive bits (0..255); 0 gives back-to-back bits.
- TIMEOUT, 16, cycles to wait for a response after the last bit (1..65535).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to send code; sampled only in IDLE.
- code  input  N  code to send; latched on the accepted start.
- unlock_valid  input  1  safe per-bit acknowledge; informational only, never changes state.
- unlock  input  1  safe reports the code was correct.
- incorrect  input  1  safe reports the code was wrong.
- busy  output  1  high from the cycle after start is accepted until the DONE cycle inclusive.
- ser_valid  output  1  registered; high for exactly one cycle per bit.
- ser_data  output  1  registered; bit value, meaningful only when ser_valid=1.
- done  output  1  one-cycle pulse when a transaction ends.
- pass  output  1  result flag; held until the next accepted start.
- fail  output  1  result flag; held until the next accepted start.
- timeout  output  1  result flag; held until the next accepted start.

Behaviour:
- Reset: all outputs 0; state IDLE; shift register, bit counter and timers cleared. Reset wins over every other event.
- Reset mid-transaction aborts it immediately: ser_valid drops the cycle after rst is sampled, and no done pulse is produced.
- State machine: IDLE, SEND, GAP, WAIT, DONE.

IDLE:
- On start=1, latch code into shift_reg, clear bit_cnt, clear pass/fail/timeout, go to SEND.
- Otherwise stay in IDLE.

SEND (exactly one cycle):
- ser_valid=1 and ser_data=shift_reg[N-1] in this cycle.
- Shift the register left by one and increment bit_cnt.
- If this was bit N-1, go to WAIT with tcnt=0.
- Else if GAP=0, go to SEND.
- Else go to GAP with gcnt=0.

GAP:
- ser_valid=0 and ser_data=0.
- gcnt increments each cycle; go to SEND after exactly GAP cycles in GAP.

WAIT:
- ser_valid=0. Inputs are sampled each cycle, in priority order:
  - unlock=1: set pass, go to DONE.
  - else incorrect=1: set fail, go to DONE.
  - else tcnt=TIMEOUT-1: set timeout, go to DONE.
  - else increment tcnt.
- unlock and incorrect asserted together resolve as pass.
- unlock/incorrect outside WAIT are ignored.

DONE (one cycle):
- done=1, then go to IDLE.
- start is ignored in DONE. It is accepted no earlier than the cycle after, i.e. in IDLE.

Timing and handshake rules:
- start while busy is ignored; there is no queueing. code changes while busy have no effect.
- Latency: first ser_valid is the cycle after start is sampled.
- Span from first to last ser_valid is (N-1)*(GAP+1)+1 cycles.
- Exactly one of pass/fail/timeout is high after done; all three are 0 before the first transaction.
- bit_cnt is wide enough to hold N; tcnt is wide enough to hold TIMEOUT; gcnt is 8 bits. No counter wraps in legal operation.

Test Plan:
- Reset, then code=4'b1011, start pulse, GAP=2 -> ser_valid pulses in cycles 1, 4, 7, 10 after start, with ser_data 1, 0, 1, 1. A safe model asserts unlock 1 cycle after the last bit -> pass=1, done pulse at cycle 12, busy low at cycle 13.
- code=4'b1001, safe model asserts incorrect 1 cycle after the last bit -> fail=1, pass=0, timeout=0, single done pulse.
- No response, TIMEOUT=16 -> timeout=1 and done exactly 16 cycles after entering WAIT; pass=fail=0.
- Second start pulse and code change while busy -> the transmitted sequence still matches the first code; exactly 4 ser_valid pulses and one done. Afterwards a new start sends the new code and clears the result flags.
- rst asserted after the 2nd bit -> ser_valid stays 0, busy=0 and all flags 0 from the next cycle, no done. A following start sends the full code from the MSB.
- GAP=0, unlock and incorrect both asserted in the first WAIT cycle -> ser_valid high for 4 consecutive cycles; result pass=1, fail=0.

Source files
------------

// File: rtl/ser_code_tx.sv
// Serial code transmitter: shifts an N-bit code out MSB first with GAP idle cycles between bits, then waits for the safe's verdict.
// First ser_valid one cycle after start is accepted; no backpressure, and start is ignored until the DONE cycle has passed.
module ser_code_tx #(
  parameter int N       = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] code,
  input  logic         unlock_valid,
  input  logic         unlock,
  input  logic         incorrect,
  output logic         busy,
  output logic         ser_valid,
  output logic         ser_data,
  output logic         done,
  output logic         pass,
  output logic         fail,
  output logic         timeout
);

  localparam int BW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [7:0]    GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]    gcnt_q, gcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          pass_d, fail_d, timeout_d;

  // The per-bit acknowledge carries no information this side acts on.
  logic unused_ack;
  assign unused_ack = unlock_valid;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gcnt_d    = gcnt_q;
    tcnt_d    = tcnt_q;
    pass_d    = pass;
    fail_d    = fail;
    timeout_d = timeout;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d   = code;
          bit_cnt_d = '0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        shift_d   = {shift_q[N-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == LAST_BIT) begin
          tcnt_d  = '0;
          state_d = S_WAIT;
        end else if (GAP == 0) begin
          state_d = S_SEND;
        end else begin
          gcnt_d  = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q + 8'd1;
        if (gcnt_q == GAP_LAST) begin
          state_d = S_SEND;
        end
      end
      S_WAIT: begin
        // unlock outranks incorrect, and both outrank the timeout
        if (unlock) begin
          pass_d  = 1'b1;
          state_d = S_DONE;
        end else if (incorrect) begin
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else if (tcnt_q == T_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gcnt_q    <= '0;
      tcnt_q    <= '0;
      busy      <= 1'b0;
      ser_valid <= 1'b0;
      ser_data  <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gcnt_q    <= gcnt_d;
      tcnt_q    <= tcnt_d;
      busy      <= (state_d != S_IDLE);
      ser_valid <= (state_d == S_SEND);
      ser_data  <= (state_d == S_SEND) && shift_d[N-1];
      done      <= (state_d == S_DONE);
      pass      <= pass_d;
      fail      <= fail_d;
      timeout   <= timeout_d;
    end
  end

endmodule
